// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, PC increment and fetch FSM encoding.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// PC register and instruction-fetch stage: req/ack to instruction memory,
// valid/ready to decode, with redirect handling that discards stale fetches.
//
// state | meaning
// IDLE  | load imem_addr from pc, or retarget pc on redirect
// REQ   | request outstanding; kill marks the returning data as stale
// VALID | instruction held for decode; pc equals inst_pc
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] next_pc,
    input  logic            redirect,
    output logic [XLEN-1:0] pc_plus4,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam logic [XLEN-1:0] RESET_PC_AL = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] target;
    logic            unused_lsbs;

    assign target      = {next_pc[XLEN-1:2], 2'b00};
    assign unused_lsbs = ^next_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC_AL;
            addr_q    <= RESET_PC_AL;
            inst_q    <= '0;
            inst_pc_q <= RESET_PC_AL;
            kill_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            kill_q    <= kill_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        kill_d    = kill_q;

        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = target;
                end else begin
                    addr_d  = pc_q;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ack) begin
                    // A redirect seen now or earlier in this request makes the data stale.
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = addr_q;
                        state_d   = VALID;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            VALID: begin
                if (redirect || inst_ready) begin
                    pc_d    = target;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pc_plus4   = pc_q + PC_STEP;
    assign imem_req   = (state_q == REQ);
    assign inst_valid = (state_q == VALID);
    assign imem_addr  = addr_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule
